// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch stage. Owns the PC, requests instruction words over a
// req/ack handshake, and holds the fetched word for decode together with its
// PC and PC+4. Execute can redirect the fetch stream at any time. A request
// that is already on the bus when a redirect arrives is squashed: the stage
// waits for its ack, throws the data away, and only then moves to the new
// target. A redirect to a target that is not word aligned parks the stage in
// a fault state until reset.
//
// Ports
//   clk              in   1   single clock, rising edge
//   reset            in   1   synchronous, active-high
//   Imem_Req_o       out  1   fetch request, held until Imem_Ack_i
//   Imem_Addr_o      out  32  fetch address (same as PC_o)
//   Imem_Ack_i       in   1   memory accepts request, data valid same cycle
//   Imem_Data_i      in   32  instruction word, sampled on req & ack
//   Stall_i          in   1   decode cannot consume the held instruction
//   Redirect_i       in   1   one-cycle redirect pulse
//   Redirect_Addr_i  in   32  redirect target
//   Inst_Valid_o     out  1   Inst_o / PC_o hold a valid instruction
//   Inst_o           out  32  instruction register (NOP when not valid)
//   PC_o             out  32  PC of Inst_o and of the current request
//   PC_Plus4_o       out  32  PC_o + 4, wrapping modulo 2^32
//   Misaligned_o     out  1   sticky misaligned-redirect flag
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0040_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    output logic        Imem_Req_o,
    output logic [31:0] Imem_Addr_o,
    input  logic        Imem_Ack_i,
    input  logic [31:0] Imem_Data_i,
    input  logic        Stall_i,
    input  logic        Redirect_i,
    input  logic [31:0] Redirect_Addr_i,
    output logic        Inst_Valid_o,
    output logic [31:0] Inst_o,
    output logic [31:0] PC_o,
    output logic [31:0] PC_Plus4_o,
    output logic        Misaligned_o
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_REQ    = 3'd1,
        ST_VALID  = 3'd2,
        ST_SQUASH = 3'd3,
        ST_FAULT  = 3'd4
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] pend_addr_q, pend_addr_d;
    logic        misaligned_q, misaligned_d;

    logic        req_s;
    logic        valid_s;
    logic [31:0] pc_plus4_s;
    logic        redir_misaligned_s;
    logic [31:0] squash_target_s;
    logic        squash_misaligned_s;

    assign pc_plus4_s         = pc_q + 32'd4;
    assign redir_misaligned_s = (Redirect_Addr_i[1:0] != 2'b00);

    // When the stale ack arrives in SQUASH, a redirect in that same cycle is
    // the most recent one and therefore wins over the pending target.
    assign squash_target_s     = Redirect_i ? Redirect_Addr_i : pend_addr_q;
    assign squash_misaligned_s = (squash_target_s[1:0] != 2'b00);

    // State and datapath registers; synchronous reset has top priority.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            pc_q         <= RESET_PC;
            inst_q       <= NOP_INST;
            pend_addr_q  <= RESET_PC;
            misaligned_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            inst_q       <= inst_d;
            pend_addr_q  <= pend_addr_d;
            misaligned_q <= misaligned_d;
        end
    end

    // Next-state and next-datapath logic.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        inst_d       = inst_q;
        pend_addr_d  = pend_addr_q;
        misaligned_d = misaligned_q;

        case (state_q)
            ST_IDLE: begin
                state_d = ST_REQ;
            end

            ST_REQ: begin
                if (Imem_Ack_i) begin
                    if (Redirect_i) begin
                        // Returned word belongs to the old stream: drop it.
                        pc_d = Redirect_Addr_i;
                        if (redir_misaligned_s) begin
                            state_d      = ST_FAULT;
                            misaligned_d = 1'b1;
                        end else begin
                            state_d = ST_REQ;
                        end
                    end else begin
                        inst_d  = Imem_Data_i;
                        state_d = ST_VALID;
                    end
                end else begin
                    if (Redirect_i) begin
                        // Address must stay stable while the request is
                        // outstanding, so park the target until the ack.
                        pend_addr_d = Redirect_Addr_i;
                        state_d     = ST_SQUASH;
                    end else begin
                        state_d = ST_REQ;
                    end
                end
            end

            ST_SQUASH: begin
                if (Imem_Ack_i) begin
                    pc_d = squash_target_s;
                    if (squash_misaligned_s) begin
                        state_d      = ST_FAULT;
                        misaligned_d = 1'b1;
                    end else begin
                        state_d = ST_REQ;
                    end
                end else begin
                    if (Redirect_i) begin
                        pend_addr_d = Redirect_Addr_i;
                    end else begin
                        pend_addr_d = pend_addr_q;
                    end
                    state_d = ST_SQUASH;
                end
            end

            ST_VALID: begin
                if (Redirect_i) begin
                    pc_d   = Redirect_Addr_i;
                    inst_d = NOP_INST;
                    if (redir_misaligned_s) begin
                        state_d      = ST_FAULT;
                        misaligned_d = 1'b1;
                    end else begin
                        state_d = ST_REQ;
                    end
                end else if (!Stall_i) begin
                    pc_d    = pc_plus4_s;
                    inst_d  = NOP_INST;
                    state_d = ST_REQ;
                end else begin
                    state_d = ST_VALID;
                end
            end

            ST_FAULT: begin
                state_d = ST_FAULT;
            end

            default: begin
                state_d      = ST_IDLE;
                pc_d         = RESET_PC;
                inst_d       = NOP_INST;
                pend_addr_d  = RESET_PC;
                misaligned_d = 1'b0;
            end
        endcase
    end

    // Output decode from the registered state.
    always_comb begin
        req_s   = 1'b0;
        valid_s = 1'b0;
        case (state_q)
            ST_IDLE:   begin req_s = 1'b0; valid_s = 1'b0; end
            ST_REQ:    begin req_s = 1'b1; valid_s = 1'b0; end
            ST_VALID:  begin req_s = 1'b0; valid_s = 1'b1; end
            ST_SQUASH: begin req_s = 1'b1; valid_s = 1'b0; end
            ST_FAULT:  begin req_s = 1'b0; valid_s = 1'b0; end
            default:   begin req_s = 1'b0; valid_s = 1'b0; end
        endcase
    end

    assign Imem_Req_o   = req_s;
    assign Imem_Addr_o  = pc_q;
    assign Inst_Valid_o = valid_s;
    assign Inst_o       = inst_q;
    assign PC_o         = pc_q;
    assign PC_Plus4_o   = pc_plus4_s;
    assign Misaligned_o = misaligned_q;

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//
// Self-checking bench for fetch_unit. Each instruction the bench expects to
// reach decode is pushed to a scoreboard queue when its ack is driven; a
// monitor pops and compares it when Inst_Valid_o rises. Directed checks cover
// reset, stall hold, redirects in VALID/REQ/SQUASH, misaligned faults, reset
// during SQUASH and PC wrap.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0040_0000;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    logic        clk;
    logic        reset;
    logic        Imem_Req_o;
    logic [31:0] Imem_Addr_o;
    logic        Imem_Ack_i;
    logic [31:0] Imem_Data_i;
    logic        Stall_i;
    logic        Redirect_i;
    logic [31:0] Redirect_Addr_i;
    logic        Inst_Valid_o;
    logic [31:0] Inst_o;
    logic [31:0] PC_o;
    logic [31:0] PC_Plus4_o;
    logic        Misaligned_o;

    int tests_run    = 0;
    int tests_failed = 0;

    // Expected {pc, inst} pairs for instructions that should reach decode.
    logic [63:0] exp_q [$];
    logic        prev_valid_r = 1'b0;

    fetch_unit #(
        .RESET_PC (RESET_PC),
        .NOP_INST (NOP_INST)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .Imem_Req_o      (Imem_Req_o),
        .Imem_Addr_o     (Imem_Addr_o),
        .Imem_Ack_i      (Imem_Ack_i),
        .Imem_Data_i     (Imem_Data_i),
        .Stall_i         (Stall_i),
        .Redirect_i      (Redirect_i),
        .Redirect_Addr_i (Redirect_Addr_i),
        .Inst_Valid_o    (Inst_Valid_o),
        .Inst_o          (Inst_o),
        .PC_o            (PC_o),
        .PC_Plus4_o      (PC_Plus4_o),
        .Misaligned_o    (Misaligned_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run = tests_run + 1;
        if (got !== exp) begin
            tests_failed = tests_failed + 1;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs set after this are seen at the next edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: compare each newly valid instruction.
    always @(negedge clk) begin
        if (!reset && Inst_Valid_o && !prev_valid_r) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_valid", 32'(Inst_Valid_o), 32'd0);
                check("sb_unexpected_inst", Inst_o, NOP_INST);
            end else begin
                logic [63:0] item;
                item = exp_q.pop_front();
                check("sb_inst", Inst_o, item[31:0]);
                check("sb_pc", PC_o, item[63:32]);
                check("sb_pc_plus4", PC_Plus4_o, item[63:32] + 32'd4);
            end
        end
        prev_valid_r = reset ? 1'b0 : Inst_Valid_o;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset           = 1'b1;
        Imem_Ack_i      = 1'b0;
        Imem_Data_i     = 32'h0;
        Stall_i         = 1'b0;
        Redirect_i      = 1'b0;
        Redirect_Addr_i = 32'h0;
        step();
        step();

        // Reset state
        check("rst_req", 32'(Imem_Req_o), 32'd0);
        check("rst_valid", 32'(Inst_Valid_o), 32'd0);
        check("rst_pc", PC_o, RESET_PC);
        check("rst_inst", Inst_o, NOP_INST);
        check("rst_mis", 32'(Misaligned_o), 32'd0);

        // T1: first fetch, zero-wait ack
        reset = 1'b0;
        step();
        check("t1_req", 32'(Imem_Req_o), 32'd1);
        check("t1_addr", Imem_Addr_o, 32'h0040_0000);
        Imem_Ack_i  = 1'b1;
        Imem_Data_i = 32'h0050_0093;
        exp_q.push_back({32'h0040_0000, 32'h0050_0093});
        step();
        Imem_Ack_i  = 1'b0;
        Imem_Data_i = 32'h0;
        check("t1_valid", 32'(Inst_Valid_o), 32'd1);
        check("t1_req_low", 32'(Imem_Req_o), 32'd0);
        check("t1_plus4", PC_Plus4_o, 32'h0040_0004);
        step();
        check("t1_next_req", 32'(Imem_Req_o), 32'd1);
        check("t1_next_addr", Imem_Addr_o, 32'h0040_0004);
        check("t1_next_valid", 32'(Inst_Valid_o), 32'd0);
        check("t1_next_inst", Inst_o, NOP_INST);

        // T2: stall holds the instruction for 3 cycles
        Imem_Ack_i  = 1'b1;
        Imem_Data_i = 32'h00A0_0113;
        exp_q.push_back({32'h0040_0004, 32'h00A0_0113});
        step();
        Imem_Ack_i = 1'b0;
        Stall_i    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("t2_hold_valid", 32'(Inst_Valid_o), 32'd1);
            check("t2_hold_pc", PC_o, 32'h0040_0004);
            check("t2_hold_inst", Inst_o, 32'h00A0_0113);
            check("t2_hold_req", 32'(Imem_Req_o), 32'd0);
        end
        Stall_i = 1'b0;
        step();
        check("t2_rel_valid", 32'(Inst_Valid_o), 32'd0);
        check("t2_rel_req", 32'(Imem_Req_o), 32'd1);
        check("t2_rel_addr", Imem_Addr_o, 32'h0040_0008);

        // T3: redirect in VALID beats stall
        Imem_Ack_i  = 1'b1;
        Imem_Data_i = 32'h0000_0033;
        exp_q.push_back({32'h0040_0008, 32'h0000_0033});
        step();
        Imem_Ack_i      = 1'b0;
        Stall_i         = 1'b1;
        Redirect_i      = 1'b1;
        Redirect_Addr_i = 32'h0040_0100;
        step();
        Redirect_i = 1'b0;
        Stall_i    = 1'b0;
        check("t3_valid", 32'(Inst_Valid_o), 32'd0);
        check("t3_req", 32'(Imem_Req_o), 32'd1);
        check("t3_addr", Imem_Addr_o, 32'h0040_0100);
        check("t3_inst", Inst_o, NOP_INST);

        // T4: redirect while request outstanding, stale ack 3 cycles later
        Redirect_i      = 1'b1;
        Redirect_Addr_i = 32'h0040_0200;
        step();
        Redirect_i = 1'b0;
        check("t4_sq_addr", Imem_Addr_o, 32'h0040_0100);
        check("t4_sq_req", 32'(Imem_Req_o), 32'd1);
        for (int i = 0; i < 2; i++) begin
            step();
            check("t4_wait_addr", Imem_Addr_o, 32'h0040_0100);
            check("t4_wait_valid", 32'(Inst_Valid_o), 32'd0);
        end
        Imem_Ack_i  = 1'b1;
        Imem_Data_i = 32'hDEAD_BEEF;
        step();
        Imem_Ack_i = 1'b0;
        check("t4_new_req", 32'(Imem_Req_o), 32'd1);
        check("t4_new_addr", Imem_Addr_o, 32'h0040_0200);
        check("t4_new_valid", 32'(Inst_Valid_o), 32'd0);
        Imem_Ack_i  = 1'b1;
        Imem_Data_i = 32'h1234_5678;
        exp_q.push_back({32'h0040_0200, 32'h1234_5678});
        step();
        Imem_Ack_i = 1'b0;
        step();
        check("t4_consume_addr", Imem_Addr_o, 32'h0040_0204);

        // T5: misaligned redirect with ack in REQ
        Redirect_i      = 1'b1;
        Redirect_Addr_i = 32'h0040_0102;
        Imem_Ack_i      = 1'b1;
        Imem_Data_i     = 32'h0000_0000;
        step();
        Redirect_i = 1'b0;
        Imem_Ack_i = 1'b0;
        check("t5_mis", 32'(Misaligned_o), 32'd1);
        check("t5_pc", PC_o, 32'h0040_0102);
        for (int i = 0; i < 20; i++) begin
            Redirect_i      = (i == 5);
            Redirect_Addr_i = 32'h0040_0300;
            step();
            check("t5_fault_req", 32'(Imem_Req_o), 32'd0);
            check("t5_fault_valid", 32'(Inst_Valid_o), 32'd0);
        end
        Redirect_i = 1'b0;
        check("t5_fault_pc", PC_o, 32'h0040_0102);
        check("t5_fault_mis", 32'(Misaligned_o), 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("t5_rst_mis", 32'(Misaligned_o), 32'd0);
        check("t5_rst_pc", PC_o, RESET_PC);
        step();
        check("t5_resume_req", 32'(Imem_Req_o), 32'd1);
        check("t5_resume_addr", Imem_Addr_o, RESET_PC);

        // T6: reset in SQUASH with a simultaneous stale ack
        Redirect_i      = 1'b1;
        Redirect_Addr_i = 32'h0040_0400;
        step();
        Redirect_i = 1'b0;
        check("t6_sq_req", 32'(Imem_Req_o), 32'd1);
        reset       = 1'b1;
        Imem_Ack_i  = 1'b1;
        Imem_Data_i = 32'hBAD0_BAD0;
        step();
        check("t6_req", 32'(Imem_Req_o), 32'd0);
        check("t6_pc", PC_o, RESET_PC);
        check("t6_inst", Inst_o, NOP_INST);
        check("t6_valid", 32'(Inst_Valid_o), 32'd0);
        reset      = 1'b0;
        Imem_Ack_i = 1'b0;
        step();
        check("t6_resume_addr", Imem_Addr_o, RESET_PC);

        // Misaligned redirect in SQUASH overrides pending target, waits for ack
        Redirect_i      = 1'b1;
        Redirect_Addr_i = 32'h0040_0404;
        step();
        Redirect_Addr_i = 32'h0040_0406;
        step();
        Redirect_i = 1'b0;
        check("sq_mis_wait", 32'(Misaligned_o), 32'd0);
        check("sq_mis_req", 32'(Imem_Req_o), 32'd1);
        check("sq_mis_addr", Imem_Addr_o, RESET_PC);
        Imem_Ack_i = 1'b1;
        step();
        Imem_Ack_i = 1'b0;
        check("sq_mis_flag", 32'(Misaligned_o), 32'd1);
        check("sq_mis_pc", PC_o, 32'h0040_0406);
        check("sq_mis_req_low", 32'(Imem_Req_o), 32'd0);

        // PC wrap at the top of the address space
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        Redirect_i      = 1'b1;
        Redirect_Addr_i = 32'hFFFF_FFFC;
        Imem_Ack_i      = 1'b1;
        step();
        Redirect_i = 1'b0;
        Imem_Ack_i = 1'b0;
        check("wrap_addr", Imem_Addr_o, 32'hFFFF_FFFC);
        check("wrap_req", 32'(Imem_Req_o), 32'd1);
        Imem_Ack_i  = 1'b1;
        Imem_Data_i = 32'h0010_0073;
        exp_q.push_back({32'hFFFF_FFFC, 32'h0010_0073});
        step();
        Imem_Ack_i = 1'b0;
        check("wrap_plus4", PC_Plus4_o, 32'h0000_0000);
        step();
        check("wrap_next_addr", Imem_Addr_o, 32'h0000_0000);

        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
